spm_seq_mul: RTL and testbench

Parametrised serial/parallel multiplier core: the next generation of our SPM datapath. It multiplies a WIDTH-bit X (parallel) by a WIDTH-bit Y (serial, LSB first) and returns the full 2*WIDTH-bit product. Signed or unsigned operation is selected per operation. Operands and results move over valid/ready handshakes. It sits behind bus wrappers (AHB/APB) and accelerator pipelines, and replaces the fixed 32-bit, low-half-only, inverted-clock arrangement.

---
 rtl/spm_pkg.sv | 19 +
 rtl/spm_array.sv | 116 +++++++++++
 rtl/spm_seq_mul.sv | 128 ++++++++++++
 tb/tb_spm_seq_mul.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared state encoding, width limits and derived-width helper
// for the serial/parallel multiplier core.
package spm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } spm_state_e;

   localparam int spm_min_width = 4;
   localparam int spm_max_width = 64;

   // Counter must hold 0..2*WIDTH
   function automatic int spm_cnt_w(input int width);
      return $clog2(2 * width + 2);
   endfunction

endpackage

// File: rtl/spm_array.sv
// spm_array: WIDTH+1-bit serial/parallel multiplier array. Carry-save cells
// cover the low WIDTH bits of X; a serial two's-complement cell covers the extended sign bit.

module spm_csa_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic s
);
   logic sum_q, sum_d;
   logic cy_q, cy_d;

   always_comb begin
      sum_d = sum_q;
      cy_d  = cy_q;
      if (clr) begin
         sum_d = 1'b0;
         cy_d  = 1'b0;
      end else if (en) begin
         sum_d = a ^ b ^ cy_q;
         cy_d  = (a & b) | (a & cy_q) | (b & cy_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= 1'b0;
         cy_q  <= 1'b0;
      end else begin
         sum_q <= sum_d;
         cy_q  <= cy_d;
      end
   end

   assign s = sum_q;
endmodule

// Serial negation: bits pass unchanged up to and including the first 1, then invert.
module spm_tcmp_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic a,
   output logic s
);
   logic sum_q, sum_d;
   logic seen_q, seen_d;

   always_comb begin
      sum_d  = sum_q;
      seen_d = seen_q;
      if (clr) begin
         sum_d  = 1'b0;
         seen_d = 1'b0;
      end else if (en) begin
         sum_d  = a ^ seen_q;
         seen_d = seen_q | a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= 1'b0;
         seen_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         seen_q <= seen_d;
      end
   end

   assign s = sum_q;
endmodule

module spm_array #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           en,
   input  logic [WIDTH:0] x,
   input  logic           y_bit,
   output logic           p
);
   // pp[i] is the registered partial-sum stream leaving cell i toward cell i-1
   logic [WIDTH:0] pp;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_csa
         spm_csa_cell u_cell (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (en),
            .a   (x[gi] & y_bit),
            .b   (pp[gi+1]),
            .s   (pp[gi])
         );
      end
   endgenerate

   spm_tcmp_cell u_tcmp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .a   (x[WIDTH] & y_bit),
      .s   (pp[WIDTH])
   );

   assign p = pp[0];
endmodule

// File: rtl/spm_seq_mul.sv
// spm_seq_mul: WIDTH x WIDTH -> 2*WIDTH serial/parallel multiplier with
// valid/ready operand and result handshakes; Y is fed LSB first.
module spm_seq_mul
   import spm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   input  logic                 in_signed,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic                 busy
);
   localparam int               CNT_W    = spm_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * WIDTH);

   generate
      if (WIDTH < spm_min_width || WIDTH > spm_max_width) begin : g_width_check
         $error("spm_seq_mul: WIDTH outside supported range");
      end
   endgenerate

   spm_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     x_q, x_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               fill_q, fill_d;
   logic               mode_q, mode_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               arr_clr;
   logic               arr_en;
   logic               arr_p;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      fill_d  = fill_q;
      mode_d  = mode_q;
      prod_d  = prod_q;
      arr_clr = 1'b0;
      arr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = {in_x[WIDTH-1] & in_signed, in_x};
               y_d     = in_y;
               fill_d  = in_y[WIDTH-1];
               mode_d  = in_signed;
               cnt_d   = '0;
               arr_clr = 1'b1;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               arr_en = 1'b1;
               y_d    = {fill_q & mode_q, y_q[WIDTH-1:1]};
               // The array output lags Y by one cycle, so cnt=0 carries no product bit
               if (cnt_q != '0) begin
                  prod_d = {arr_p, prod_q[2*WIDTH-1:1]};
               end
               if (cnt_q == LAST_CNT) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (out_ready || abort) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         fill_q  <= 1'b0;
         mode_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fill_q  <= fill_d;
         mode_q  <= mode_d;
         prod_q  <= prod_d;
      end
   end

   spm_array #(
      .WIDTH (WIDTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .clr   (arr_clr),
      .en    (arr_en),
      .x     (x_q),
      .y_bit (y_q[0]),
      .p     (arr_p)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == COMPUTE);
   assign out_prod  = prod_q;

endmodule

// File: tb/tb_spm_seq_mul.sv
// Self-checking bench for spm_seq_mul: directed cases on WIDTH 8 and 32, plus
// randomized traffic on WIDTH 4/8/17/32/64 checked against an arithmetic model.
module tb_spm_seq_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: extend both operands to 128 bits per mode, multiply, keep 2*w bits
   function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input bit s, input int w);
      logic [127:0] lowm, xe, ye, mask;
      lowm = (128'd1 << w) - 128'd1;
      xe   = {64'd0, x} & lowm;
      ye   = {64'd0, y} & lowm;
      if (s && x[w-1]) xe = xe | ~lowm;
      if (s && y[w-1]) ye = ye | ~lowm;
      mask = (w == 64) ? {128{1'b1}} : ((128'd1 << (2 * w)) - 128'd1);
      return (xe * ye) & mask;
   endfunction

   function automatic logic [63:0] rnd_opnd(input int w);
      logic [63:0] v;
      case ($urandom_range(7))
         0:       v = {64{1'b1}};
         1:       v = 64'd1 << (w - 1);
         2:       v = 64'd0;
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   // ---------------- directed instances (WIDTH 8 and 32) ----------------
   logic        rst_d;
   logic        dv8, dv32, ds, dab, dordy;
   logic [31:0] dx, dy;
   logic        rdy8, ov8, bz8, rdy32, ov32, bz32;
   logic [15:0] p8;
   logic [63:0] p32;
   bit          dir_done = 1'b0;

   spm_seq_mul #(.WIDTH(8)) u_d8 (
      .clk(clk), .rst(rst_d), .in_valid(dv8), .in_ready(rdy8),
      .in_x(dx[7:0]), .in_y(dy[7:0]), .in_signed(ds), .abort(dab),
      .out_valid(ov8), .out_ready(dordy), .out_prod(p8), .busy(bz8)
   );

   spm_seq_mul #(.WIDTH(32)) u_d32 (
      .clk(clk), .rst(rst_d), .in_valid(dv32), .in_ready(rdy32),
      .in_x(dx), .in_y(dy), .in_signed(ds), .abort(dab),
      .out_valid(ov32), .out_ready(dordy), .out_prod(p32), .busy(bz32)
   );

   function automatic logic dov(input bit w32);
      return w32 ? ov32 : ov8;
   endfunction
   function automatic logic drdy(input bit w32);
      return w32 ? rdy32 : rdy8;
   endfunction
   function automatic logic [63:0] dprod(input bit w32);
      return w32 ? p32 : {48'd0, p8};
   endfunction

   // One operation with out_ready high; called at a negedge in IDLE
   task automatic dir_op(input bit w32, input logic [31:0] x, input logic [31:0] y,
                         input bit s, input bit ab, input logic [63:0] expv, input string nm);
      int lat;
      @(negedge clk);
      dx = x; dy = y; ds = s; dordy = 1'b1; dab = ab;
      if (w32) dv32 = 1'b1; else dv8 = 1'b1;
      chk({nm, "_in_ready"}, drdy(w32), 1);
      @(negedge clk);
      dv8 = 1'b0; dv32 = 1'b0; dab = 1'b0;
      lat = 1;
      while (!dov(w32) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, lat, w32 ? 66 : 18);
      chk({nm, "_prod"}, dprod(w32), expv);
      @(negedge clk);
      chk({nm, "_idle_after"}, {dov(w32), drdy(w32)}, 2'b01);
   endtask

   task automatic watch_quiet(input string nm, input int n);
      int hits;
      hits = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (ov8) hits++;
      end
      chk(nm, hits, 0);
   endtask

   initial begin : directed
      int lat;
      dv8 = 1'b0; dv32 = 1'b0; dx = '0; dy = '0; ds = 1'b0; dab = 1'b0; dordy = 1'b0;
      rst_d = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_hold_d8", {rdy8, ov8, bz8, p8}, {3'b100, 16'h0});
      rst_d = 1'b0;
      @(negedge clk);
      chk("reset_d8", {rdy8, ov8, bz8, p8}, {3'b100, 16'h0});
      chk("reset_d32", {rdy32, ov32, bz32, p32}, {3'b100, 64'h0});

      dir_op(1'b0, 32'd3, 32'd5, 1'b0, 1'b0, 64'h000F, "u8_3x5");
      dir_op(1'b0, 32'hFF, 32'hFF, 1'b0, 1'b0, 64'hFE01, "u8_ffxff");
      dir_op(1'b0, 32'h80, 32'h80, 1'b1, 1'b0, 64'h4000, "s8_80x80");
      dir_op(1'b0, 32'hFF, 32'h01, 1'b1, 1'b1, 64'hFFFF, "s8_ffx01_abort_idle");
      dir_op(1'b1, 32'hFFFF_FFF1, 32'd20, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FED4, "s32_m15x20");
      dir_op(1'b1, 32'd7, 32'd9, 1'b0, 1'b0, 64'h3F, "u32_7x9");

      // Backpressure: result must hold while out_ready is low; in_valid ignored
      @(negedge clk);
      dx = 32'h12; dy = 32'h34; ds = 1'b0; dordy = 1'b0; dv8 = 1'b1;
      @(negedge clk);
      dv8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold", {ov8, rdy8, p8}, {2'b10, 16'h03A8});
         if (i == 3) begin
            dx = 32'h55; dy = 32'h66; dv8 = 1'b1;
         end else begin
            dv8 = 1'b0;
         end
         @(negedge clk);
      end
      dordy = 1'b1;
      @(negedge clk);
      chk("bp_release", {ov8, rdy8, bz8}, 3'b010);
      @(negedge clk);
      chk("bp_pulse_ignored", {ov8, rdy8, bz8}, 3'b010);

      // Abort while counter is at 5
      dx = 32'hA5; dy = 32'h5A; ds = 1'b0; dv8 = 1'b1;
      @(negedge clk);
      dv8 = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_pre_busy", bz8, 1);
      dab = 1'b1;
      @(negedge clk);
      dab = 1'b0;
      chk("abort_idle", {ov8, bz8, rdy8}, 3'b001);
      watch_quiet("abort_no_valid", 40);

      // Reset in the middle of a second operation
      dx = 32'h0F; dy = 32'h0E; dv8 = 1'b1;
      @(negedge clk);
      dv8 = 1'b0;
      repeat (7) @(negedge clk);
      chk("rst_pre_busy", bz8, 1);
      rst_d = 1'b1;
      #1;
      chk("rst_async", {ov8, bz8, rdy8, p8}, {3'b001, 16'h0});
      @(negedge clk);
      rst_d = 1'b0;
      watch_quiet("rst_no_valid", 40);
      dir_op(1'b0, 32'd2, 32'd3, 1'b0, 1'b0, 64'h6, "u8_2x3_after_rst");

      // Abort while holding a result in DONE
      @(negedge clk);
      dx = 32'd9; dy = 32'd9; ds = 1'b0; dordy = 1'b0; dv8 = 1'b1;
      @(negedge clk);
      dv8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("done_abort_prod", {ov8, p8}, {1'b1, 16'h0051});
      dab = 1'b1;
      @(negedge clk);
      dab = 1'b0;
      dordy = 1'b1;
      chk("done_abort_idle", {ov8, rdy8}, 2'b01);
      dir_done = 1'b1;
   end

   // ---------------- randomized instances ----------------
   logic rst_r;

   for (genvar gi = 0; gi < 5; gi++) begin : g_rnd
      localparam int W    = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 17 : (gi == 3) ? 32 : 64;
      localparam int NOPS = 20000 / (2 * W + 6);

      logic             iv, ir, is, ab, ov, ordy, bz;
      logic [W-1:0]     ix, iy;
      logic [2*W-1:0]   op;
      logic [2*W-1:0]   exp_q[$];
      int               acc_q[$];
      int               got = 0;
      bit               drv_done = 1'b0;

      spm_seq_mul #(.WIDTH(W)) u_dut (
         .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir),
         .in_x(ix), .in_y(iy), .in_signed(is), .abort(ab),
         .out_valid(ov), .out_ready(ordy), .out_prod(op), .busy(bz)
      );

      // Driver: operands are presented as soon as the previous one is taken,
      // so in_valid is frequently held high while the core is busy.
      initial begin : drv
         logic [127:0] e;
         int wc;
         iv = 1'b0; ix = '0; iy = '0; is = 1'b0; ab = 1'b0;
         @(negedge clk);
         while (rst_r) @(negedge clk);
         for (int n = 0; n < NOPS; n++) begin
            if ($urandom_range(3) == 0) begin
               iv = 1'b0;
               repeat ($urandom_range(3)) @(negedge clk);
            end
            ix = W'(rnd_opnd(W));
            iy = W'(rnd_opnd(W));
            is = 1'($urandom_range(1));
            iv = 1'b1;
            wc = 0;
            while (!ir && wc < 4 * (2 * W + 3) + 64) begin
               @(negedge clk);
               wc++;
            end
            if (!ir) begin
               chk($sformatf("w%0d_accept_timeout", W), 0, 1);
               break;
            end
            e = ref_mul(64'(ix), 64'(iy), is, W);
            exp_q.push_back(e[2*W-1:0]);
            acc_q.push_back(cyc);
            @(negedge clk);
         end
         iv = 1'b0;
         wc = 0;
         while (exp_q.size() != 0 && wc < 1000) begin
            @(negedge clk);
            wc++;
         end
         chk($sformatf("w%0d_drained", W), exp_q.size(), 0);
         chk($sformatf("w%0d_result_count", W), got, NOPS);
         drv_done = 1'b1;
      end

      // Compare process: every cycle out_valid is high the product must match
      // the oldest outstanding operation, and its rise must follow acceptance by 2W+2 cycles.
      initial begin : cmp
         bit prev_ov;
         ordy = 1'b0;
         prev_ov = 1'b0;
         forever begin
            @(negedge clk);
            if (rst_r) begin
               prev_ov = 1'b0;
               continue;
            end
            if (ov) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("w%0d_spurious_valid", W), 1, 0);
               end else begin
                  chk($sformatf("w%0d_prod", W), op, exp_q[0]);
                  chk($sformatf("w%0d_busy_in_done", W), bz, 0);
                  if (!prev_ov) chk($sformatf("w%0d_latency", W), cyc - acc_q[0], 2 * W + 2);
               end
            end
            prev_ov = ov;
            ordy = ($urandom_range(3) != 0);
            if (ov && ordy && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
               got++;
            end
         end
      end
   end

   // ---------------- model pins and run control ----------------
   initial begin : main
      bit all_done;
      chk("model_u8_3x5",     ref_mul(64'd3, 64'd5, 1'b0, 8), 128'h000F);
      chk("model_u8_ffxff",   ref_mul(64'hFF, 64'hFF, 1'b0, 8), 128'hFE01);
      chk("model_s8_80x80",   ref_mul(64'h80, 64'h80, 1'b1, 8), 128'h4000);
      chk("model_s8_ffx01",   ref_mul(64'hFF, 64'h01, 1'b1, 8), 128'hFFFF);
      chk("model_s32_m15x20", ref_mul(64'hFFFF_FFF1, 64'd20, 1'b1, 32), 128'hFFFF_FFFF_FFFF_FED4);
      chk("model_s64_m1xm1",  ref_mul({64{1'b1}}, {64{1'b1}}, 1'b1, 64), 128'h1);
      chk("model_u64_max",    ref_mul({64{1'b1}}, {64{1'b1}}, 1'b0, 64),
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

      rst_r = 1'b1;
      repeat (3) @(negedge clk);
      rst_r = 1'b0;
      all_done = 1'b0;
      for (int t = 0; t < 70000 && !all_done; t++) begin
         @(negedge clk);
         all_done = dir_done && g_rnd[0].drv_done && g_rnd[1].drv_done &&
                    g_rnd[2].drv_done && g_rnd[3].drv_done && g_rnd[4].drv_done;
      end
      chk("run_complete", all_done, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
